// File: rtl/box_filter_pkg.sv
// -----------------------------------------------------------------------------
// box_filter_pkg
//   Shared definitions for the adaptive-threshold pipeline (box_filter,
//   input_rom_reader, threshold_rom_reader, threshold).
//   - Default image geometry (address widths).
//   - Box-filter FSM state encoding.
//   - Reciprocal constant for the divide-by-9 and the tap count.
//   - Tap-index to (dx, dy) helper functions for the 3x3 window.
// -----------------------------------------------------------------------------
package box_filter_pkg;

    localparam int WIDTH_BITS_DEF  = 7;
    localparam int HEIGHT_BITS_DEF = 7;

    // round(65536/9); (sum*RECIP)>>16 == floor(sum/9) for every sum up to 9*255
    localparam int RECIP_DEF = 7282;
    localparam int NUM_TAPS  = 9;

    typedef enum logic [2:0] {
        ST_READ,
        ST_ACC,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Tap k walks the window row by row: dx = k%3 - 1
    function automatic logic signed [1:0] tap_dx(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: tap_dx = -2'sd1;
            4'd1, 4'd4, 4'd7: tap_dx = 2'sd0;
            default:          tap_dx = 2'sd1;
        endcase
    endfunction

    // dy = k/3 - 1
    function automatic logic signed [1:0] tap_dy(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: tap_dy = -2'sd1;
            4'd3, 4'd4, 4'd5: tap_dy = 2'sd0;
            default:          tap_dy = 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/box_filter_clamp_coord.sv
// -----------------------------------------------------------------------------
// clamp_coord
//   Combinational centre + delta (-1/0/+1) address generator for one image
//   axis. The result saturates at 0 and at the axis maximum, so edge pixels
//   are replicated instead of wrapping.
//   Ports:
//     i_centre  centre coordinate
//     i_delta   signed step, -1..+1
//     o_coord   clamped coordinate
// -----------------------------------------------------------------------------
module clamp_coord #(
    parameter int BITS = 7
) (
    input  logic [BITS-1:0]   i_centre,
    input  logic signed [1:0] i_delta,
    output logic [BITS-1:0]   o_coord
);

    always_comb begin
        o_coord = i_centre;
        if (i_delta == -2'sd1) begin
            if (i_centre != '0) o_coord = i_centre - BITS'(1);
        end else if (i_delta == 2'sd1) begin
            if (i_centre != '1) o_coord = i_centre + BITS'(1);
        end
    end

endmodule

// File: rtl/box_filter.sv
// -----------------------------------------------------------------------------
// box_filter
//   Produces the adaptive threshold map: for every pixel, in raster order,
//   the floor mean of its 3x3 neighbourhood (edges replicated) minus OFFSET,
//   saturated at 0. Each pixel costs exactly 12 cycles:
//     READ x9 -> ACC -> CALC -> WRITE, then DONE after the last pixel.
//   Ports:
//     clock           system clock, rising edge
//     reset           asynchronous, active-low
//     oImageCol/Row   image read address (synchronous ROM, 1-cycle latency)
//     iImageData      image pixel for the address of the previous cycle
//     oThresholdCol/Row/Data  threshold write address and value
//     oThresholdWren  one-cycle write strobe per pixel
//     finished        sticky once the whole map has been written
// -----------------------------------------------------------------------------
module box_filter
    import box_filter_pkg::*;
#(
    parameter int WIDTH_BITS  = WIDTH_BITS_DEF,
    parameter int HEIGHT_BITS = HEIGHT_BITS_DEF,
    parameter int OFFSET      = 5,
    parameter int RECIP       = RECIP_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   finished
);

    state_t                 r_state;
    logic [3:0]             r_k;
    logic [WIDTH_BITS-1:0]  r_col;
    logic [HEIGHT_BITS-1:0] r_row;
    logic [11:0]            r_sum;
    logic [WIDTH_BITS-1:0]  r_img_col;
    logic [HEIGHT_BITS-1:0] r_img_row;
    logic [WIDTH_BITS-1:0]  r_thr_col;
    logic [HEIGHT_BITS-1:0] r_thr_row;
    logic [7:0]             r_thr_data;
    logic                   r_wren;
    logic                   r_fin;

    logic signed [1:0]      w_dx;
    logic signed [1:0]      w_dy;
    logic [WIDTH_BITS-1:0]  w_tap_col;
    logic [HEIGHT_BITS-1:0] w_tap_row;
    logic [8:0]             w_mean;
    logic [7:0]             w_thr;
    logic                   w_last;

    assign w_dx = tap_dx(r_k);
    assign w_dy = tap_dy(r_k);

    clamp_coord #(.BITS(WIDTH_BITS)) u_clamp_col (
        .i_centre (r_col),
        .i_delta  (w_dx),
        .o_coord  (w_tap_col)
    );

    clamp_coord #(.BITS(HEIGHT_BITS)) u_clamp_row (
        .i_centre (r_row),
        .i_delta  (w_dy),
        .o_coord  (w_tap_row)
    );

    // The address must be on the port during the tap's own READ cycle so the
    // ROM returns it in the next one; outside READ the last address is held.
    assign oImageCol = (r_state == ST_READ) ? w_tap_col : r_img_col;
    assign oImageRow = (r_state == ST_READ) ? w_tap_row : r_img_row;

    // Multiply-and-shift divide by 9 on a 25-bit product; mean fits in 8 bits.
    assign w_mean = 9'((25'(r_sum) * 25'(RECIP)) >> 16);

    always_comb begin
        w_thr = '0;
        if (w_mean >= 9'(OFFSET)) w_thr = 8'(w_mean - 9'(OFFSET));
    end

    assign w_last = (r_col == '1) && (r_row == '1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_READ;
            r_k        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_sum      <= '0;
            r_img_col  <= '0;
            r_img_row  <= '0;
            r_thr_col  <= '0;
            r_thr_row  <= '0;
            r_thr_data <= '0;
            r_wren     <= 1'b0;
            r_fin      <= 1'b0;
        end else begin
            case (r_state)
                ST_READ: begin
                    r_img_col <= w_tap_col;
                    r_img_row <= w_tap_row;
                    // Data on the bus belongs to tap k-1; nothing yet at k=0.
                    if (r_k != 4'd0) r_sum <= r_sum + 12'(iImageData);
                    r_k <= r_k + 4'd1;
                    if (r_k == 4'(NUM_TAPS - 1)) r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_sum   <= r_sum + 12'(iImageData);
                    r_state <= ST_CALC;
                end
                ST_CALC: begin
                    r_thr_col  <= r_col;
                    r_thr_row  <= r_row;
                    r_thr_data <= w_thr;
                    r_wren     <= 1'b1;
                    r_state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wren <= 1'b0;
                    r_sum  <= '0;
                    r_k    <= '0;
                    if (w_last) begin
                        r_fin   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        if (r_col == '1) begin
                            r_col <= '0;
                            r_row <= r_row + HEIGHT_BITS'(1);
                        end else begin
                            r_col <= r_col + WIDTH_BITS'(1);
                        end
                        r_state <= ST_READ;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_READ;
                end
            endcase
        end
    end

    assign oThresholdCol  = r_thr_col;
    assign oThresholdRow  = r_thr_row;
    assign oThresholdData = r_thr_data;
    assign oThresholdWren = r_wren;
    assign finished       = r_fin;

endmodule

// File: tb/tb_box_filter.sv
module tb_box_filter;

    localparam int WB     = 3;
    localparam int HB     = 3;
    localparam int W      = 1 << WB;
    localparam int H      = 1 << HB;
    localparam int NPIX   = W * H;
    localparam int PERIOD = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Two instances run in lock-step on the same image: OFFSET 0 and OFFSET 5.
    logic [WB-1:0] ic0, ic5, tc0, tc5;
    logic [HB-1:0] ir0, ir5, tr0, tr5;
    logic [7:0]    id0, id5, td0, td5;
    logic          tw0, tw5, f0, f5;

    box_filter #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(0)) dut0 (
        .clock(clock), .reset(reset),
        .oImageCol(ic0), .oImageRow(ir0), .iImageData(id0),
        .oThresholdCol(tc0), .oThresholdRow(tr0), .oThresholdData(td0),
        .oThresholdWren(tw0), .finished(f0)
    );

    box_filter #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(5)) dut5 (
        .clock(clock), .reset(reset),
        .oImageCol(ic5), .oImageRow(ir5), .iImageData(id5),
        .oThresholdCol(tc5), .oThresholdRow(tr5), .oThresholdData(td5),
        .oThresholdWren(tw5), .finished(f5)
    );

    // Synchronous image ROM, one-cycle latency
    logic [7:0] img [H][W];
    always @(posedge clock) begin
        id0 <= img[ir0][ic0];
        id5 <= img[ir5][ic5];
    end

    int checks = 0;
    int errors = 0;
    int cap0 [NPIX];
    int cap5 [NPIX];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(v);
    endtask

    function automatic int model(input int c, input int r, input int off);
        int s, cc, rr, m;
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                cc = c + dx; rr = r + dy;
                if (cc < 0) cc = 0;
                if (cc > W - 1) cc = W - 1;
                if (rr < 0) rr = 0;
                if (rr > H - 1) rr = H - 1;
                s += int'(img[rr][cc]);
            end
        m = s / 9;
        return (m >= off) ? m - off : 0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_out0"}, int'({ic0, ir0, tc0, tr0, td0, tw0, f0}), 0);
        check({tag, "_out5"}, int'({ic5, ir5, tc5, tr5, td5, tw5, f5}), 0);
    endtask

    // Hold reset for a few cycles, check outputs, then release on a negedge.
    task automatic restart(input string tag);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_zero(tag);
        reset = 1'b1;
    endtask

    // Watch writes until stop_after have been seen, checking order, data and spacing.
    task automatic run_pass(input string tag, input int stop_after);
        int nw, cyc, last;
        nw = 0; cyc = 0; last = -1;
        while (nw < stop_after && cyc < (NPIX + 2) * PERIOD) begin
            @(negedge clock);
            cyc++;
            if (tw0) begin
                check({tag, "_wren5"}, int'(tw5), 1);
                check({tag, "_col0"}, int'(tc0), nw % W);
                check({tag, "_row0"}, int'(tr0), nw / W);
                check({tag, "_col5"}, int'(tc5), nw % W);
                check({tag, "_row5"}, int'(tr5), nw / W);
                check({tag, "_data0"}, int'(td0), model(nw % W, nw / W, 0));
                check({tag, "_data5"}, int'(td5), model(nw % W, nw / W, 5));
                if (last < 0) check({tag, "_first_lat"}, cyc, 11);
                else          check({tag, "_spacing"}, cyc - last, PERIOD);
                check({tag, "_fin_early"}, int'(f0), 0);
                cap0[nw] = int'(td0);
                cap5[nw] = int'(td5);
                last = cyc;
                nw++;
            end
        end
        check({tag, "_writes"}, nw, stop_after);
    endtask

    task automatic run_full(input string tag);
        int extra;
        run_pass(tag, NPIX);
        @(negedge clock);
        check({tag, "_fin0"}, int'(f0), 1);
        check({tag, "_fin5"}, int'(f5), 1);
        extra = 0;
        repeat (30) begin
            @(negedge clock);
            if (tw0 || tw5 || !f0 || !f5) extra++;
        end
        check({tag, "_done_hold"}, extra, 0);
    endtask

    initial begin
        // Uniform 100
        fill(100);
        restart("rst_u100");
        run_full("u100");
        check("u100_hand5", cap5[10], 95);
        check("u100_hand0", cap0[63], 100);

        // Uniform 3: OFFSET 5 saturates at 0
        fill(3);
        restart("rst_u3");
        run_full("u3");
        check("u3_hand5", cap5[0], 0);
        check("u3_hand0", cap0[20], 3);

        // All 255: exact mean at maximum sum
        fill(255);
        restart("rst_u255");
        run_full("u255");
        check("u255_hand0", cap0[27], 255);
        check("u255_hand5", cap5[63], 250);

        // Impulse at (4,4)
        fill(0);
        img[4][4] = 8'd255;
        restart("rst_imp");
        run_full("imp");
        check("imp_centre", cap0[4*W+4], 28);
        check("imp_ne", cap0[3*W+5], 28);
        check("imp_sw", cap0[5*W+3], 28);
        check("imp_out_n", cap0[2*W+4], 0);
        check("imp_out_e", cap0[4*W+6], 0);
        check("imp_off5", cap5[4*W+4], 23);

        // Corner clamp: 90 at top-left and bottom-right
        fill(0);
        img[0][0] = 8'd90;
        img[H-1][W-1] = 8'd90;
        restart("rst_corner");
        run_full("corner");
        check("corner_00", cap0[0], 40);
        check("corner_10", cap0[1], 20);
        check("corner_01", cap0[W], 20);
        check("corner_11", cap0[W+1], 10);
        check("corner_20", cap0[2], 0);
        check("corner_00_off5", cap5[0], 35);
        check("corner_br", cap0[NPIX-1], 40);
        check("corner_br_left", cap0[NPIX-2], 20);

        // Reset in the middle of pixel 31
        fill(0);
        img[4][4] = 8'd255;
        restart("rst_mid_pre");
        run_pass("mid_a", 30);
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero("mid_async");
        @(negedge clock);
        reset = 1'b1;
        run_full("mid_b");
        check("mid_b_centre", cap0[4*W+4], 28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/box_filter.md
Name: box_filter

Overview:
- Upstream stage of `threshold`: computes the per-pixel adaptive threshold map that `threshold` compares against the image.
- Scans the 8-bit greyscale image in raster order and reads a 3x3 neighbourhood through the image-memory address port. Border pixels are replicated at the image edge.
- Writes mean-minus-offset, saturated at 0, into threshold memory over a col/row/data/wren port.
- Raises `finished` when the whole map is written.

Parameters:
- WIDTH_BITS, 7, column address width; WIDTH = 2**WIDTH_BITS.
- HEIGHT_BITS, 7, row address width; HEIGHT = 2**HEIGHT_BITS.
- OFFSET, 5, constant C subtracted from the local mean (0..255).
- RECIP, 7282, round(65536/9). Used as mean = (sum*RECIP)>>16, which is exact floor(sum/9) for sum 0..2295.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state; high = run.
- oImageCol  out  WIDTH_BITS  image read column.
- oImageRow  out  HEIGHT_BITS  image read row.
- iImageData  in  8  image pixel; synchronous ROM, valid exactly one cycle after its address.
- oThresholdCol  out  WIDTH_BITS  threshold write column.
- oThresholdRow  out  HEIGHT_BITS  threshold write row.
- oThresholdData  out  8  threshold value.
- oThresholdWren  out  1  write strobe, one cycle per pixel.
- finished  out  1  high once all WIDTH*HEIGHT values are written; sticky until reset.

Behaviour:
- Reset (reset=0, async): every output is 0. State=READ, centre (col,row)=(0,0), tap k=0, sum=0.
- Processing starts automatically on the first rising edge with reset=1. There is no start input.
- Scan order is row-major: col increments fastest, then row.
- Taps: k=0..8 with dy=k/3-1 and dx=k%3-1.
  - Addresses are clamped: col+dx limited to [0, WIDTH-1], row+dy limited to [0, HEIGHT-1].
  - No wrap-around at the edges; the edge pixel is reused.
- States:
  - READ (9 cycles): drive the tap-k address and increment k. From the 2nd READ cycle onward, add the previous tap's iImageData to sum. After k=8 -> ACC.
  - ACC (1 cycle): add the tap-8 data, giving the full 12-bit sum (0..2295) -> CALC.
  - CALC (1 cycle):
    - mean = (sum*RECIP)>>16, using a 25-bit product.
    - thr = mean - OFFSET if mean >= OFFSET, otherwise 0.
    - Register thr and the centre coordinates into the threshold outputs -> WRITE.
  - WRITE (1 cycle): oThresholdWren=1 with col/row/data stable. Clear sum and k.
    - Last pixel (WIDTH-1, HEIGHT-1) -> DONE.
    - Otherwise advance the centre -> READ.
  - DONE: finished=1, wren=0, all outputs held. Stays in DONE until reset.
- Timing:
  - Exactly 12 cycles per pixel; wren pulses are exactly 12 cycles apart.
  - Total of WIDTH*HEIGHT wren pulses.
  - finished rises on the cycle after the final WRITE.
- oThresholdWren is 0 in every state except WRITE.
- Image address outputs outside READ: don't-care; held at their last value.
- Reset mid-operation:
  - Outputs and finished go to 0 immediately, and any partial sum is discarded.
  - After release, the scan restarts at (0,0).
- Sum width is 12 bits; no overflow is possible at 9*255.

Decomposition:
- Shared package holds:
  - WIDTH_BITS/HEIGHT_BITS defaults, shared with input_rom_reader, threshold_rom_reader and threshold.
  - State encoding (READ, ACC, CALC, WRITE, DONE).
  - RECIP and the tap count 9.
- One natural sub-module, `clamp_coord`: combinational centre+delta -> clamped address, parameterised on bit width and instantiated once per axis.

Test Plan:
- Uniform image 100, OFFSET=5:
  - Every one of the 16384 writes has data 95.
  - Writes are in raster order starting at (0,0).
  - Wren pulse spacing is 12 cycles.
  - finished rises one cycle after the write to (127,127).
- Uniform image 3, OFFSET=5 -> all data 0 (saturation).
- All-255 image, OFFSET=0 -> all data 255 (RECIP exactness at maximum sum).
- Impulse test: pixel (10,10)=255, rest 0, OFFSET=0.
  - The 3x3 block centred at (10,10) reads 28.
  - All other pixels read 0.
- Corner clamp test: pixel (0,0)=90, rest 0, OFFSET=0.
  - (0,0)=40, (1,0)=20, (0,1)=20, (1,1)=10.
  - (2,0)=0.
- Reset mid-run: pull reset low during the 500th pixel.
  - Same cycle: all outputs 0 and finished=0.
  - After release, the first write is to (0,0), and a full 16384-write pass completes with correct data.
